// File: rtl/echo_timer_pkg.sv
// echo_timer_pkg: state encoding and clock-derived timing constants for the echo timer.
package echo_timer_pkg;

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_e;

    function automatic int cyc_per_us(input int clk_frequency);
        return clk_frequency / 1_000_000;
    endfunction

    function automatic int holdoff_cycles(input int clk_frequency, input int period_ms);
        return period_ms * 1000 * cyc_per_us(clk_frequency);
    endfunction

endpackage

// File: rtl/us_tick.sv
// us_tick: one-cycle tick every microsecond, restartable so each state times from its own entry.
module us_tick
    import echo_timer_pkg::*;
#(
    parameter int CLK_FREQUENCY = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CYC = cyc_per_us(CLK_FREQUENCY);
    localparam int CW = $clog2(CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick = cnt_q == LAST;
        cnt_d = (clear || tick) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt_q <= '0;
        else cnt_q <= cnt_d;

endmodule

// File: rtl/echo_timer.sv
// echo_timer: HC-SR04 style ranger driver; fires a trigger pulse and times the echo in whole microseconds.
module echo_timer
    import echo_timer_pkg::*;
#(
    parameter int CLK_FREQUENCY = 50_000_000,
    parameter int TRIG_US = 10,
    parameter int TIMEOUT_US = 30_000,
    parameter int PERIOD_MS = 60,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             echo,
    output logic             trig,
    output logic             busy,
    output logic             valid,
    output logic             timeout,
    output logic [WIDTH-1:0] echo_us
);

    localparam int CYC = cyc_per_us(CLK_FREQUENCY);
    localparam int HOLD_CYC = holdoff_cycles(CLK_FREQUENCY, PERIOD_MS);
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam logic [HW-1:0] TRIG_LAST = HW'(TRIG_US * CYC - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [WIDTH-1:0] TO_LAST = WIDTH'(TIMEOUT_US - 1);

    state_e state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] us_q, us_d;
    logic [WIDTH-1:0] echo_us_q, echo_us_d;
    logic [2:0] sync_q, sync_d;
    logic valid_q, valid_d;
    logic timeout_q, timeout_d;
    logic clear, tick, echo_rise, echo_fall, us_done;

    us_tick #(.CLK_FREQUENCY(CLK_FREQUENCY)) u_tick (
        .clk  (clk),
        .reset(reset),
        .clear(clear),
        .tick (tick)
    );

    // sync_q[1] is the synchronized echo; sync_q[2] delays it one more cycle for edge detection
    always_comb begin
        sync_d = {sync_q[1:0], echo};
        echo_rise = sync_q[1] && !sync_q[2];
        echo_fall = !sync_q[1] && sync_q[2];
        us_done = tick && us_q == TO_LAST;
    end

    always_comb begin
        state_d = state_q;
        valid_d = 1'b0;
        timeout_d = 1'b0;
        echo_us_d = echo_us_q;
        case (state_q)
            IDLE: if (start) state_d = TRIG;
            TRIG: if (hold_q == TRIG_LAST) state_d = WAIT_RISE;
            WAIT_RISE:
                if (echo_rise) state_d = MEASURE;
                else if (us_done) begin
                    state_d = HOLDOFF;
                    timeout_d = 1'b1;
                end
            MEASURE:
                if (echo_fall) begin
                    state_d = HOLDOFF;
                    valid_d = 1'b1;
                    echo_us_d = us_q + WIDTH'(tick);
                end else if (us_done) begin
                    state_d = HOLDOFF;
                    timeout_d = 1'b1;
                end
            // a request present as holdoff expires chains straight into the next trigger,
            // so a held start yields triggers exactly one period apart
            HOLDOFF: if (hold_q == HOLD_LAST) state_d = start ? TRIG : IDLE;
            default: state_d = IDLE;
        endcase
        clear = state_d != state_q;
        hold_d = (clear && state_d == TRIG) ? '0 : hold_q + 1'b1;
        us_d = clear ? '0 : us_q + WIDTH'(tick);
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q <= IDLE;
            hold_q <= '0;
            us_q <= '0;
            echo_us_q <= '0;
            sync_q <= '0;
            valid_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q <= hold_d;
            us_q <= us_d;
            echo_us_q <= echo_us_d;
            sync_q <= sync_d;
            valid_q <= valid_d;
            timeout_q <= timeout_d;
        end

    assign trig = state_q == TRIG;
    assign busy = state_q != IDLE;
    assign valid = valid_q;
    assign timeout = timeout_q;
    assign echo_us = echo_us_q;

endmodule

// File: tb/tb_echo_timer.sv
// tb_echo_timer: directed checks of echo_timer scaled to 4 MHz, 300 us timeout, 1 ms period.
module tb_echo_timer;

    localparam int CLK_FREQUENCY = 4_000_000;
    localparam int TRIG_US = 10;
    localparam int TIMEOUT_US = 300;
    localparam int PERIOD_MS = 1;
    localparam int WIDTH = 16;
    localparam int TRIG_CYC = 40;
    localparam int TO_CYC = 1200;
    localparam int HOLD_CYC = 4000;

    logic clk, reset, start, echo, trig, busy, valid, timeout;
    logic [WIDTH-1:0] echo_us;

    int checks = 0, errors = 0;
    int cyc = 0, trig_rises = 0, rise_cyc = 0, rise_prev = 0, fall_cyc = 0, to_cyc = 0;
    int trig_hi = 0, busy_hi = 0, valids = 0, timeouts = 0, both = 0;
    logic trig_p = 1'b0;

    echo_timer #(
        .CLK_FREQUENCY(CLK_FREQUENCY),
        .TRIG_US(TRIG_US),
        .TIMEOUT_US(TIMEOUT_US),
        .PERIOD_MS(PERIOD_MS),
        .WIDTH(WIDTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .echo(echo),
        .trig(trig),
        .busy(busy),
        .valid(valid),
        .timeout(timeout),
        .echo_us(echo_us)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        trig_p <= trig;
        if (trig && !trig_p) begin
            trig_rises <= trig_rises + 1;
            rise_prev <= rise_cyc;
            rise_cyc <= cyc;
        end
        if (!trig && trig_p) fall_cyc <= cyc;
        if (trig) trig_hi <= trig_hi + 1;
        if (busy) busy_hi <= busy_hi + 1;
        if (valid) valids <= valids + 1;
        if (timeout) begin
            timeouts <= timeouts + 1;
            to_cyc <= cyc;
        end
        if (valid && timeout) both <= both + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_trig_fall();
        int n = 0;
        while (trig && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("trig_fall", int'(trig), 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("idle", int'(busy), 0);
    endtask

    task automatic echo_run(input string tag, input int dly, input int wid, input int exp_us);
        int v0, t0;
        v0 = valids;
        t0 = timeouts;
        pulse_start();
        wait_trig_fall();
        repeat (dly) @(negedge clk);
        echo = 1'b1;
        repeat (wid) @(negedge clk);
        echo = 1'b0;
        wait_idle();
        check({tag, "_us"}, int'(echo_us), exp_us);
        check({tag, "_valid"}, valids - v0, 1);
        check({tag, "_to"}, timeouts - t0, 0);
    endtask

    initial begin
        int v0, t0, b0, h0, r0, n;
        reset = 1'b0;
        start = 1'b0;
        echo = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_trig", int'(trig), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_to", int'(timeout), 0);
        check("rst_us", int'(echo_us), 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", int'(busy), 0);

        // 200 us wait then a 250 us echo, with stray start requests while busy
        v0 = valids; t0 = timeouts; b0 = busy_hi; h0 = trig_hi; r0 = trig_rises;
        pulse_start();
        check("norm_busy", int'(busy), 1);
        check("norm_trig", int'(trig), 1);
        wait_trig_fall();
        repeat (800) @(negedge clk);
        echo = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (999) @(negedge clk);
        echo = 1'b0;
        repeat (100) @(negedge clk);
        pulse_start();
        wait_idle();
        check("norm_trig_width", trig_hi - h0, TRIG_CYC);
        check("norm_us", int'(echo_us), 250);
        check("norm_valid", valids - v0, 1);
        check("norm_to", timeouts - t0, 0);
        check("norm_rises", trig_rises - r0, 1);
        check("norm_busy_len", busy_hi - b0, HOLD_CYC);

        // no echo at all
        v0 = valids; t0 = timeouts; b0 = busy_hi;
        pulse_start();
        wait_trig_fall();
        wait_idle();
        check("noecho_to", timeouts - t0, 1);
        check("noecho_valid", valids - v0, 0);
        check("noecho_us", int'(echo_us), 250);
        check("noecho_time", to_cyc - fall_cyc, TO_CYC);
        check("noecho_busy_len", busy_hi - b0, HOLD_CYC);

        // echo rises 100 us after trig and never falls: 3 sync/detect cycles + 300 us of echo
        v0 = valids; t0 = timeouts;
        pulse_start();
        wait_trig_fall();
        repeat (400) @(negedge clk);
        echo = 1'b1;
        wait_idle();
        echo = 1'b0;
        check("stuck_to", timeouts - t0, 1);
        check("stuck_valid", valids - v0, 0);
        check("stuck_time", to_cyc - fall_cyc, 400 + 3 + TO_CYC);

        // echo already high when trig drops: no rising edge, so it times out
        v0 = valids; t0 = timeouts;
        echo = 1'b1;
        pulse_start();
        wait_trig_fall();
        wait_idle();
        echo = 1'b0;
        check("prehigh_to", timeouts - t0, 1);
        check("prehigh_valid", valids - v0, 0);
        check("prehigh_time", to_cyc - fall_cyc, TO_CYC);

        // widths off tick boundaries: floor(cycles / 4)
        echo_run("off1", 3, 149, 37);
        echo_run("off2", 77, 403, 100);
        echo_run("w299", 5, 1199, 299);
        echo_run("w300", 6, 1200, 300);

        // start held high: triggers exactly one period apart
        r0 = trig_rises;
        n = 0;
        start = 1'b1;
        while (trig_rises - r0 < 3 && n < 13000) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("held_rises", trig_rises - r0, 3);
        check("held_period", rise_cyc - rise_prev, HOLD_CYC);
        wait_idle();

        // reset in the middle of MEASURE
        v0 = valids; t0 = timeouts;
        pulse_start();
        wait_trig_fall();
        repeat (40) @(negedge clk);
        echo = 1'b1;
        repeat (200) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_trig", int'(trig), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_valid", int'(valid), 0);
        check("mid_rst_to", int'(timeout), 0);
        check("mid_rst_us", int'(echo_us), 0);
        repeat (3) @(negedge clk);
        echo = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_strobes", (valids - v0) + (timeouts - t0), 0);

        echo_run("us1", 10, 4, 1);
        echo_run("us250", 20, 1000, 250);

        check("no_overlap", both, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
